// File: rtl/circle_hit_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : circle_hit_scheduler_if
// Description : Pixel request and hit result handshakes of circle_hit_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface circle_hit_scheduler_if #(
  parameter int IDX_W   = 2,
  parameter int COLOR_W = 12
);
  logic               px_valid;
  logic               px_ready;
  logic [9:0]         px_x;
  logic [9:0]         px_y;
  logic               res_valid;
  logic               res_ready;
  logic               res_hit;
  logic [IDX_W-1:0]   res_idx;
  logic [COLOR_W-1:0] res_color;

  modport master (
    output px_valid, px_x, px_y, res_ready,
    input  px_ready, res_valid, res_hit, res_idx, res_color
  );

  modport slave (
    input  px_valid, px_x, px_y, res_ready,
    output px_ready, res_valid, res_hit, res_idx, res_color
  );
endinterface
`default_nettype wire

// File: rtl/circle_hit_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : circle_hit_scheduler
// Description : Scans a table of circle slots one per cycle for a pixel and
//               returns the lowest-index hit. Optional macro
//               CIRCLE_EARLY_EXIT_EN ends the scan right after the first hit.
// Revision    : 1.0 - initial release
// ============================================================================
module circle_hit_scheduler #(
  parameter int                 NUM_CIRCLES = 4,
  parameter int                 IDX_W       = 2,
  parameter int                 COLOR_W     = 12,
  parameter logic [COLOR_W-1:0] BG_COLOR    = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  circle_hit_scheduler_if.slave bus,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [9:0]            cfg_x,
  input  logic [9:0]            cfg_y,
  input  logic [9:0]            cfg_rad,
  input  logic                  cfg_active,
  input  logic [COLOR_W-1:0]    cfg_color,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IDX_W-1:0] C_LAST_SLOT = IDX_W'(NUM_CIRCLES - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;

  logic [9:0]         r_cx     [NUM_CIRCLES];
  logic [9:0]         r_cy     [NUM_CIRCLES];
  logic [9:0]         r_rad    [NUM_CIRCLES];
  logic               r_active [NUM_CIRCLES];
  logic [COLOR_W-1:0] r_scolor [NUM_CIRCLES];

  logic [9:0]         r_px_x;
  logic [9:0]         r_px_y;
  logic [IDX_W-1:0]   r_slot;
  logic               r_hit;
  logic [IDX_W-1:0]   r_idx;
  logic [COLOR_W-1:0] r_color;

  logic               w_idx_ok;
  logic               w_cfg_wr;
  logic               w_last;
  logic [10:0]        w_dx;
  logic [10:0]        w_dy;
  logic [9:0]         w_adx;
  logic [9:0]         w_ady;
  logic [19:0]        w_dx2;
  logic [19:0]        w_dy2;
  logic [19:0]        w_r2;
  logic [20:0]        w_d2;
  logic               w_hit;

  // A full power-of-two table needs no range check on the write index.
  generate
    if (NUM_CIRCLES == (1 << IDX_W)) begin : g_idx_full
      assign w_idx_ok = 1'b1;
    end else begin : g_idx_part
      assign w_idx_ok = ({1'b0, cfg_idx} < (IDX_W+1)'(NUM_CIRCLES));
    end
  endgenerate

  assign w_cfg_wr = cfg_we && (r_state == ST_IDLE) && w_idx_ok;
  assign w_last   = (r_slot == C_LAST_SLOT);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CIRCLES; i++) begin
        r_cx[i]     <= '0;
        r_cy[i]     <= '0;
        r_rad[i]    <= '0;
        r_active[i] <= 1'b0;
        r_scolor[i] <= '0;
      end
    end else if (w_cfg_wr) begin
      r_cx[cfg_idx]     <= cfg_x;
      r_cy[cfg_idx]     <= cfg_y;
      r_rad[cfg_idx]    <= cfg_rad;
      r_active[cfg_idx] <= cfg_active;
      r_scolor[cfg_idx] <= cfg_color;
    end
  end

  // Squares are taken on magnitudes so the 21-bit sum never wraps.
  always_comb begin
    w_dx  = {1'b0, r_px_x} - {1'b0, r_cx[r_slot]};
    w_dy  = {1'b0, r_px_y} - {1'b0, r_cy[r_slot]};
    w_adx = w_dx[10] ? (~w_dx[9:0] + 10'd1) : w_dx[9:0];
    w_ady = w_dy[10] ? (~w_dy[9:0] + 10'd1) : w_dy[9:0];
    w_dx2 = {10'd0, w_adx} * {10'd0, w_adx};
    w_dy2 = {10'd0, w_ady} * {10'd0, w_ady};
    w_r2  = {10'd0, r_rad[r_slot]} * {10'd0, r_rad[r_slot]};
    w_d2  = {1'b0, w_dx2} + {1'b0, w_dy2};
    w_hit = r_active[r_slot] && ({1'b0, w_r2} >= w_d2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.px_valid) begin
          w_next_state = ST_SCAN;
        end
      end
      ST_SCAN: begin
`ifdef CIRCLE_EARLY_EXIT_EN
        if (w_last || w_hit) begin
          w_next_state = ST_DONE;
        end
`else
        if (w_last) begin
          w_next_state = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.px_ready  = (r_state == ST_IDLE);
    bus.res_valid = (r_state == ST_DONE);
    busy          = (r_state == ST_SCAN) || (r_state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_px_x  <= '0;
      r_px_y  <= '0;
      r_slot  <= '0;
      r_hit   <= 1'b0;
      r_idx   <= '0;
      r_color <= BG_COLOR;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.px_valid) begin
            r_px_x  <= bus.px_x;
            r_px_y  <= bus.px_y;
            r_slot  <= '0;
            r_hit   <= 1'b0;
            r_idx   <= '0;
            r_color <= BG_COLOR;
          end
        end
        ST_SCAN: begin
          r_slot <= r_slot + 1'b1;
          // Only the first hit is kept, so the lowest index wins.
          if (w_hit && !r_hit) begin
            r_hit   <= 1'b1;
            r_idx   <= r_slot;
            r_color <= r_scolor[r_slot];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.res_hit   = r_hit;
  assign bus.res_idx   = r_idx;
  assign bus.res_color = r_color;

endmodule
`default_nettype wire
